// File: rtl/exec_pkg.sv
// Shared types for the execute stage.
//   alu_op_e     : ALU operation codes (4 bits, codes 11..15 are unknown)
//   exec_side_t  : memory/writeback sideband carried alongside each beat
//   exec_state_e : redirect-shadow FSM states
//   src_w()      : width of an operand-source select for n forwarding slots
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic        mem_to_reg;
        logic [1:0]  bytes;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        logic [4:0]  rd;
        logic        reg_we;
    } exec_side_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SHADOW = 1'b1
    } exec_state_e;

    // Shadow counter holds BRANCH_SHADOW-1, so 3 bits covers shadows of 0..7.
    localparam int SHADOW_CNT_W = 3;

    // Select value 0 means "register operand", 1..n pick a forwarding slot.
    function automatic int src_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/executer_pipe_if.sv
// Bundle of all execute-stage handshake and data signals except clk/reset.
//   slave  : the execute stage (consumes upstream beat, produces result beat)
//   master : the surrounding pipeline / testbench
interface executer_pipe_if import exec_pkg::*; #(
    parameter int XLEN     = 32,
    parameter int FWD_SRCS = 2,
    localparam int SRC_W   = src_w(FWD_SRCS)
);
    logic                               flush;
    logic                               in_valid;
    logic                               in_ready;
    logic [3:0]                         alu_op;
    logic [XLEN-1:0]                    alu_a;
    logic [XLEN-1:0]                    alu_b;
    logic [SRC_W-1:0]                   a_src;
    logic [SRC_W-1:0]                   b_src;
    logic [FWD_SRCS-1:0][XLEN-1:0]      fwd_data;
    logic [XLEN-1:0]                    pc;
    logic [XLEN-1:0]                    imm;
    logic                               branch_en;
    logic                               jal_en;
    logic                               jalr_en;
    exec_side_t                         side_in;
    logic                               out_valid;
    logic                               out_ready;
    logic [XLEN-1:0]                    alu_result;
    logic                               unknown_op;
    exec_side_t                         side_out;
    logic                               redirect_valid;
    logic [XLEN-1:0]                    redirect_addr;

    modport slave (
        input  flush, in_valid, alu_op, alu_a, alu_b, a_src, b_src, fwd_data,
               pc, imm, branch_en, jal_en, jalr_en, side_in, out_ready,
        output in_ready, out_valid, alu_result, unknown_op, side_out,
               redirect_valid, redirect_addr
    );

    modport master (
        output flush, in_valid, alu_op, alu_a, alu_b, a_src, b_src, fwd_data,
               pc, imm, branch_en, jal_en, jalr_en, side_in, out_ready,
        input  in_ready, out_valid, alu_result, unknown_op, side_out,
               redirect_valid, redirect_addr
    );
endinterface

// File: rtl/addr_calc.sv
// Control-flow target and link computation.
//   pc_i, imm_i, rs1_i          : instruction address, immediate, resolved operand a
//   cond_i                      : branch condition (ALU result non-zero)
//   branch_i, jal_i, jalr_i     : control-flow class
//   redirect_o, target_o, link_o: take redirect, its target, return address
module addr_calc #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic            cond_i,
    input  logic            branch_i,
    input  logic            jal_i,
    input  logic            jalr_i,
    output logic            redirect_o,
    output logic [XLEN-1:0] target_o,
    output logic [XLEN-1:0] link_o
);
    logic [XLEN-1:0] jalr_sum;
    assign jalr_sum   = rs1_i + imm_i;
    // JALR clears bit 0 of the computed target.
    assign target_o   = jalr_i ? {jalr_sum[XLEN-1:1], 1'b0} : pc_i + imm_i;
    assign link_o     = pc_i + XLEN'(4);
    assign redirect_o = jal_i | jalr_i | (branch_i & cond_i);
endmodule

// File: rtl/alu.sv
// Combinational integer ALU.
//   op_i      : alu_op_e code
//   a_i, b_i  : operands (shift amount is the low bits of b_i)
//   y_o       : result, zero for unknown codes
//   unknown_o : op_i is not a defined operation
module alu import exec_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] y_o,
    output logic            unknown_o
);
    localparam int SHW = $clog2(XLEN);
    logic [SHW-1:0] shamt;
    assign shamt = b_i[SHW-1:0];

    always_comb begin
        y_o       = '0;
        unknown_o = 1'b0;
        case (op_i)
            ALU_ADD:   y_o = a_i + b_i;
            ALU_SUB:   y_o = a_i - b_i;
            ALU_AND:   y_o = a_i & b_i;
            ALU_OR:    y_o = a_i | b_i;
            ALU_XOR:   y_o = a_i ^ b_i;
            ALU_SLL:   y_o = a_i << shamt;
            ALU_SRL:   y_o = a_i >> shamt;
            ALU_SRA:   y_o = $unsigned($signed(a_i) >>> shamt);
            ALU_SLT:   y_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU:  y_o = {{(XLEN-1){1'b0}}, a_i < b_i};
            ALU_PASSB: y_o = b_i;
            default:   unknown_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/exec_fwd_mux.sv
// Operand select: register value or one of FWD_SRCS forwarded values.
//   sel_i : 0 = reg_i, k = fwd_i[k-1]; anything past FWD_SRCS falls back to reg_i
//   reg_i : register-file operand
//   fwd_i : forwarded values, slot 0 in the LSBs
//   y_o   : selected operand
module exec_fwd_mux import exec_pkg::*; #(
    parameter int XLEN     = 32,
    parameter int FWD_SRCS = 2,
    localparam int SRC_W   = src_w(FWD_SRCS)
) (
    input  logic [SRC_W-1:0]              sel_i,
    input  logic [XLEN-1:0]               reg_i,
    input  logic [FWD_SRCS-1:0][XLEN-1:0] fwd_i,
    output logic [XLEN-1:0]               y_o
);
    always_comb begin
        y_o = reg_i;
        for (int k = 0; k < FWD_SRCS; k++) begin
            if (int'(sel_i) == k + 1) y_o = fwd_i[k];
        end
    end
endmodule

// File: rtl/executer_pipe.sv
// Single-stage execute pipe: operand forwarding, ALU, control-flow redirect,
// and a wrong-path shadow that kills BRANCH_SHADOW cycles of fires after a
// redirect. Output beat is registered with valid/ready backpressure.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : executer_pipe_if slave (upstream beat in, result beat out,
//                redirect pulse, flush)
module executer_pipe import exec_pkg::*; #(
    parameter int XLEN          = 32,
    parameter int FWD_SRCS      = 2,
    parameter int BRANCH_SHADOW = 2
) (
    input  logic          clk,
    input  logic          reset,
    executer_pipe_if.slave bus
);
    localparam int CW = SHADOW_CNT_W;

    logic [XLEN-1:0] opa, opb, alu_y, tgt, link;
    logic            alu_unk, redir;

    exec_fwd_mux #(.XLEN(XLEN), .FWD_SRCS(FWD_SRCS)) u_fwd_a (
        .sel_i(bus.a_src), .reg_i(bus.alu_a), .fwd_i(bus.fwd_data), .y_o(opa));
    exec_fwd_mux #(.XLEN(XLEN), .FWD_SRCS(FWD_SRCS)) u_fwd_b (
        .sel_i(bus.b_src), .reg_i(bus.alu_b), .fwd_i(bus.fwd_data), .y_o(opb));

    alu #(.XLEN(XLEN)) u_alu (
        .op_i(bus.alu_op), .a_i(opa), .b_i(opb), .y_o(alu_y), .unknown_o(alu_unk));

    addr_calc #(.XLEN(XLEN)) u_addr (
        .pc_i(bus.pc), .imm_i(bus.imm), .rs1_i(opa), .cond_i(|alu_y),
        .branch_i(bus.branch_en), .jal_i(bus.jal_en), .jalr_i(bus.jalr_en),
        .redirect_o(redir), .target_o(tgt), .link_o(link));

    exec_state_e     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q;
    logic            unk_q;
    exec_side_t      side_q;
    logic            rv_q;
    logic [XLEN-1:0] raddr_q;

    logic in_ready, fire, fire_ok, take_redir;

    assign in_ready   = !out_valid_q || bus.out_ready;
    assign fire       = bus.in_valid && in_ready;
    // A killed fire is still accepted upstream but leaves no trace here.
    assign fire_ok    = fire && !bus.flush && (state_q == ST_RUN);
    assign take_redir = fire_ok && redir;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (take_redir && BRANCH_SHADOW > 0) begin
                        state_d = ST_SHADOW;
                        cnt_d   = CW'(BRANCH_SHADOW - 1);
                    end
                end
                ST_SHADOW: begin
                    // Counts every cycle, whether or not anything is offered.
                    if (cnt_q == '0) state_d = ST_RUN;
                    else             cnt_d   = cnt_q - CW'(1);
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (bus.flush)          out_valid_d = 1'b0;
        else if (fire_ok)       out_valid_d = 1'b1;
        else if (bus.out_ready) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            unk_q       <= 1'b0;
            side_q      <= '0;
            rv_q        <= 1'b0;
            raddr_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            rv_q        <= take_redir;
            if (take_redir) raddr_q <= tgt;
            if (fire_ok) begin
                // Jumps write back the return address instead of the ALU value.
                result_q <= (bus.jal_en || bus.jalr_en) ? link : alu_y;
                unk_q    <= alu_unk;
                side_q   <= bus.side_in;
            end
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid_q;
    assign bus.alu_result     = result_q;
    assign bus.unknown_op     = unk_q;
    assign bus.side_out       = side_q;
    assign bus.redirect_valid = rv_q;
    assign bus.redirect_addr  = raddr_q;
endmodule

// File: tb/tb_executer_pipe.sv
module tb_executer_pipe;
    import exec_pkg::*;

    localparam int XLEN = 32;
    localparam int FWD  = 2;
    localparam int BS   = 2;

    localparam exec_side_t S1 = '{1'b1, 2'b10, 32'hCAFEBABE, 1'b1, 1'b0, 5'd7,  1'b1};
    localparam exec_side_t S2 = '{1'b0, 2'b01, 32'h12345678, 1'b0, 1'b1, 5'd19, 1'b0};
    localparam exec_side_t S3 = '{1'b1, 2'b11, 32'h0BADF00D, 1'b1, 1'b1, 5'd31, 1'b1};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    executer_pipe_if #(.XLEN(XLEN), .FWD_SRCS(FWD)) bus ();

    executer_pipe #(.XLEN(XLEN), .FWD_SRCS(FWD), .BRANCH_SHADOW(BS)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush = 0; bus.in_valid = 0; bus.alu_op = 4'd0;
        bus.alu_a = '0; bus.alu_b = '0; bus.a_src = '0; bus.b_src = '0;
        bus.pc = '0; bus.imm = '0; bus.branch_en = 0; bus.jal_en = 0;
        bus.jalr_en = 0; bus.side_in = '0;
    endtask

    task automatic beat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1; bus.alu_op = op; bus.alu_a = a; bus.alu_b = b;
        bus.a_src = '0; bus.b_src = '0; bus.branch_en = 0; bus.jal_en = 0;
        bus.jalr_en = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle(); bus.out_ready = 1; bus.fwd_data = '0;
        #2 reset = 0;
        beat(ALU_ADD, 5, 7); bus.side_in = S1;
        tick(); tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.alu_result !== '0) begin errors++; $display("FAIL rst_result got %h exp 0", bus.alu_result); end
        checks++; if (bus.side_out !== '0) begin errors++; $display("FAIL rst_side got %h exp 0", bus.side_out); end
        checks++; if (bus.redirect_valid !== 1'b0 || bus.redirect_addr !== '0) begin errors++; $display("FAIL rst_redir got %b/%h exp 0/0", bus.redirect_valid, bus.redirect_addr); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
        idle(); reset = 1;
        tick();
    endtask

    task automatic test_add();
        beat(ALU_ADD, 5, 7); bus.side_in = S1;
        tick(); idle();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.alu_result !== 32'd12) begin errors++; $display("FAIL add_result got %h exp c", bus.alu_result); end
        checks++; if (bus.unknown_op !== 1'b0) begin errors++; $display("FAIL add_unknown got %b exp 0", bus.unknown_op); end
        checks++; if (bus.side_out !== S1) begin errors++; $display("FAIL add_side got %h exp %h", bus.side_out, S1); end
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL add_redir got %b exp 0", bus.redirect_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_fwd();
        bus.fwd_data[0] = 32'h0000DEAD; bus.fwd_data[1] = 32'h00000100;
        beat(ALU_ADD, 32'h999, 4); bus.a_src = 2;
        tick();
        checks++; if (bus.alu_result !== 32'h104) begin errors++; $display("FAIL fwd_slot1 got %h exp 104", bus.alu_result); end
        beat(ALU_ADD, 32'h999, 32'h777); bus.a_src = 1; bus.b_src = 2;
        tick();
        checks++; if (bus.alu_result !== 32'hDFAD) begin errors++; $display("FAIL fwd_both got %h exp dfad", bus.alu_result); end
        beat(ALU_ADD, 32'h20, 4); bus.a_src = 3;
        tick();
        checks++; if (bus.alu_result !== 32'h24 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL fwd_oor got %h/%b exp 24/1", bus.alu_result, bus.out_valid); end
        idle(); bus.fwd_data = '0;
        tick();
    endtask

    task automatic test_ops();
        logic [3:0]  op  [7] = '{4'd1, 4'd7, 4'd8, 4'd9, 4'd5, 4'd3, 4'd15};
        logic [31:0] av  [7] = '{32'd5, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'hF0, 32'd1};
        logic [31:0] bv  [7] = '{32'd7, 32'd4, 32'd1, 32'd1, 32'd31, 32'h0F, 32'd1};
        logic [31:0] ex  [7] = '{32'hFFFFFFFE, 32'hF8000000, 32'd1, 32'd0, 32'h80000000, 32'hFF, 32'd0};
        logic        unk [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            beat(op[i], av[i], bv[i]);
            tick();
            checks++;
            if (bus.unknown_op !== unk[i] || (!unk[i] && bus.alu_result !== ex[i])) begin
                errors++;
                $display("FAIL op%0d got %h/%b exp %h/%b", i, bus.alu_result, bus.unknown_op, ex[i], unk[i]);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 0;
        beat(ALU_ADD, 1, 2); bus.side_in = S2;
        tick();
        beat(ALU_ADD, 10, 20); bus.side_in = S3;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.alu_result !== 32'd3 || bus.side_out !== S2 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got v%b r%h s%h rdy%b exp v1 r3 s%h rdy0", i, bus.out_valid, bus.alu_result, bus.side_out, bus.in_ready, S2);
            end
            tick();
        end
        bus.out_ready = 1; #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready got %b exp 1", bus.in_ready); end
        tick(); idle();
        checks++; if (bus.out_valid !== 1'b1 || bus.alu_result !== 32'd30 || bus.side_out !== S3) begin errors++; $display("FAIL bp_second got v%b r%h s%h exp v1 r1e s%h", bus.out_valid, bus.alu_result, bus.side_out, S3); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_jal_shadow();
        bus.out_ready = 1;
        beat(ALU_ADD, 0, 0); bus.jal_en = 1; bus.pc = 32'h40; bus.imm = 32'h10;
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.alu_result !== 32'h44) begin errors++; $display("FAIL jal_link got v%b r%h exp v1 r44", bus.out_valid, bus.alu_result); end
        checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_addr !== 32'h50) begin errors++; $display("FAIL jal_redir got %b/%h exp 1/50", bus.redirect_valid, bus.redirect_addr); end
        beat(ALU_ADD, 1, 1);
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL jal_kill1 got v%b rv%b exp 0/0", bus.out_valid, bus.redirect_valid); end
        checks++; if (bus.redirect_addr !== 32'h50) begin errors++; $display("FAIL jal_addr_hold got %h exp 50", bus.redirect_addr); end
        beat(ALU_ADD, 2, 2);
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL jal_kill2 got %b exp 0", bus.out_valid); end
        beat(ALU_ADD, 3, 0);
        tick(); idle();
        checks++; if (bus.out_valid !== 1'b1 || bus.alu_result !== 32'd3 || bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL jal_third got v%b r%h rv%b exp 1/3/0", bus.out_valid, bus.alu_result, bus.redirect_valid); end
        tick();
    endtask

    task automatic test_jalr_no_ready();
        bus.out_ready = 0;
        beat(ALU_ADD, 32'h101, 0); bus.jalr_en = 1; bus.pc = 32'h80; bus.imm = 32'h10;
        tick(); idle();
        checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_addr !== 32'h110 || bus.alu_result !== 32'h84) begin errors++; $display("FAIL jalr_redir got rv%b a%h r%h exp 1/110/84", bus.redirect_valid, bus.redirect_addr, bus.alu_result); end
        tick();
        checks++; if (bus.redirect_valid !== 1'b0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL jalr_pulse got rv%b v%b exp 0/1", bus.redirect_valid, bus.out_valid); end
        tick();
        bus.out_ready = 1;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL jalr_drain got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_branch();
        bus.out_ready = 1;
        beat(ALU_XOR, 3, 3); bus.branch_en = 1; bus.pc = 32'h200; bus.imm = 32'h20;
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.alu_result !== 32'd0 || bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL br_nt got v%b r%h rv%b exp 1/0/0", bus.out_valid, bus.alu_result, bus.redirect_valid); end
        beat(ALU_XOR, 3, 4); bus.branch_en = 1; bus.pc = 32'h200; bus.imm = 32'h20;
        tick(); idle();
        checks++; if (bus.out_valid !== 1'b1 || bus.alu_result !== 32'd7 || bus.redirect_valid !== 1'b1 || bus.redirect_addr !== 32'h220) begin errors++; $display("FAIL br_t got v%b r%h rv%b a%h exp 1/7/1/220", bus.out_valid, bus.alu_result, bus.redirect_valid, bus.redirect_addr); end
        tick(); tick();
    endtask

    task automatic test_flush();
        bus.out_ready = 1;
        beat(ALU_ADD, 0, 0); bus.jal_en = 1; bus.pc = 32'h300; bus.imm = 32'h8;
        tick();
        checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_addr !== 32'h308) begin errors++; $display("FAIL fl_jal got %b/%h exp 1/308", bus.redirect_valid, bus.redirect_addr); end
        beat(ALU_ADD, 1, 1); bus.flush = 1;
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL fl_kill got v%b rv%b exp 0/0", bus.out_valid, bus.redirect_valid); end
        bus.flush = 0; beat(ALU_ADD, 4, 5);
        tick(); idle();
        checks++; if (bus.out_valid !== 1'b1 || bus.alu_result !== 32'd9) begin errors++; $display("FAIL fl_run got v%b r%h exp 1/9", bus.out_valid, bus.alu_result); end
        bus.out_ready = 0;
        tick();
        bus.flush = 1;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fl_bp got %b exp 0", bus.out_valid); end
        bus.flush = 0; bus.out_ready = 1;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 0;
        beat(ALU_ADD, 0, 0); bus.jal_en = 1; bus.pc = 32'h40; bus.imm = 32'h10; bus.side_in = S1;
        tick(); idle();
        checks++; if (bus.out_valid !== 1'b1 || bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL rm_pre got v%b rv%b exp 1/1", bus.out_valid, bus.redirect_valid); end
        #2 reset = 0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.alu_result !== '0 || bus.unknown_op !== 1'b0 ||
            bus.side_out !== '0 || bus.redirect_valid !== 1'b0 || bus.redirect_addr !== '0) begin
            errors++;
            $display("FAIL rm_async got v%b r%h u%b s%h rv%b a%h exp all 0", bus.out_valid, bus.alu_result, bus.unknown_op, bus.side_out, bus.redirect_valid, bus.redirect_addr);
        end
        #1 reset = 1;
        bus.out_ready = 1;
        beat(ALU_ADD, 2, 3);
        tick(); idle();
        checks++; if (bus.out_valid !== 1'b1 || bus.alu_result !== 32'd5 || bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL rm_after got v%b r%h rv%b exp 1/5/0", bus.out_valid, bus.alu_result, bus.redirect_valid); end
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_fwd();
        test_ops();
        test_backpressure();
        test_jal_shadow();
        test_jalr_no_ready();
        test_branch();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/executer_pipe.md
EXECUTER_PIPE -- requirements
Module: executer_pipe

Interface
- REQ-001 SHALL have parameter XLEN, default 32, datapath width.
- REQ-002 SHALL have parameter FWD_SRCS, default 2, number of forwarding sources; SRC_W = $clog2(FWD_SRCS+1).
- REQ-003 SHALL have parameter BRANCH_SHADOW, default 2, cycles of wrong-path kill after a redirect; legal range 0..7.
- REQ-004 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
- REQ-005 SHALL have these ports:
  clk  in  1  clock, rising edge.
  reset  in  1  asynchronous, active-low.
  flush  in  1  synchronous pipeline kill.
  in_valid  in  1  upstream beat present.
  in_ready  out  1  beat accepted when high with in_valid.
  alu_op  in  4  ALU operation.
  alu_a, alu_b  in  XLEN  register-file operands.
  a_src, b_src  in  SRC_W  0 = register operand; k = fwd_data slot k-1.
  fwd_data  in  FWD_SRCS*XLEN  packed forwarded values, slot 0 in LSBs.
  pc, imm  in  XLEN  instruction address, immediate.
  branch_en, jal_en, jalr_en  in  1  control-flow class.
  side_in  in  exec_side_t  memory/writeback sideband.
  out_valid  out  1  result beat present.
  out_ready  in  1  downstream accepts.
  alu_result  out  XLEN  registered ALU result.
  unknown_op  out  1  registered, qualified by out_valid.
  side_out  out  exec_side_t  registered sideband.
  redirect_valid  out  1  one-cycle redirect pulse.
  redirect_addr  out  XLEN  redirect target.

Function
- REQ-006 fire = in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready.
- REQ-007 Operand a SHALL be alu_a when a_src=0, fwd_data slot a_src-1 when 1..FWD_SRCS, and alu_a when out of range; b likewise.
- REQ-008 On an unkilled fire, alu_result, unknown_op and side_out SHALL load on the same edge; out_valid SHALL rise; latency exactly 1 cycle.
- REQ-009 With out_valid=1 and out_ready=0, all outputs SHALL hold stable; no beat SHALL be lost or duplicated.
- REQ-010 out_valid SHALL clear on out_ready when there is no unkilled fire that cycle.
- REQ-011 FSM states: RUN, SHADOW.
- REQ-012 In RUN, an unkilled fire whose addr_calc reports redirect SHALL pulse redirect_valid high for exactly one cycle after the edge, with redirect_addr held until the next redirect.
- REQ-013 On the same fire, when BRANCH_SHADOW>0, the FSM SHALL enter SHADOW with counter = BRANCH_SHADOW-1; when BRANCH_SHADOW=0 it SHALL stay in RUN.
- REQ-014 The redirecting beat itself SHALL still be emitted on out_valid, carrying the link value for JAL/JALR.
- REQ-015 In SHADOW, every fire SHALL be killed: accepted, not emitted, no redirect.
- REQ-016 SHADOW SHALL last exactly BRANCH_SHADOW cycles, counted per cycle and independent of in_valid; it SHALL return to RUN when the counter is 0.
- REQ-017 flush SHALL clear out_valid, force RUN, zero the counter and kill any same-cycle fire; flush has priority over fire and redirect.
- REQ-018 redirect_valid SHALL NOT depend on out_ready.

Reset
- REQ-019 While reset=0, all of the following SHALL be 0: out_valid, alu_result, unknown_op, side_out, redirect_valid, redirect_addr and the counter; state SHALL be RUN.
- REQ-020 Reset asserted mid-SHADOW or mid-backpressure SHALL discard all state; the first fire after deassertion SHALL be handled in RUN.

Structure
- REQ-021 exec_pkg SHALL hold: alu_op codes; exec_side_t {mem_to_reg, bytes[1:0], wdata[31:0], we, re, rd[4:0], reg_we}; the state enum; the SRC_W helper.
- REQ-022 SHALL instantiate the existing alu and addr_calc, plus one new sub-module, exec_fwd_mux, parametrised by XLEN and FWD_SRCS, instantiated once per operand.

Verification
- REQ-023 ADD, a=5, b=7, src=0, out_ready=1 -> next cycle out_valid=1, alu_result=12, unknown_op=0.
- REQ-024 a_src=2, fwd_data slot1=0x100, b=4, ADD -> alu_result=0x104; a_src=3 with FWD_SRCS=2 -> alu_a used.
- REQ-025 out_ready=0 for 3 cycles with a second beat waiting -> in_ready=0, outputs stable; out_ready=1 -> first beat drains, second beat appears next cycle.
- REQ-026 JAL, pc=0x40, imm=0x10, BRANCH_SHADOW=2, in_valid held high -> redirect_valid for 1 cycle with addr 0x50; next 2 fires dropped; third fire emitted.
- REQ-027 flush in first SHADOW cycle coincident with a fire -> out_valid=0 next cycle, state RUN, no redirect; following beat emitted normally.
- REQ-028 reset=0 asserted during backpressure with out_valid=1 -> all outputs 0 immediately, with no clock edge required.
